// File: rtl/bp_be_fflags_merge.sv
// rtl/bp_be_fflags_merge.sv - N-port fflags gather, stage, sticky fold, FS-dirty and per-port event counters
module bp_be_fflags_merge #(
  parameter int num_wb_ports_p = 2,
  parameter int cnt_width_p    = 16
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_wb_ports_p-1:0]             wb_fflags_w_v_i,
  input  logic [5*num_wb_ports_p-1:0]           wb_fflags_i,
  input  logic                                  flush_i,
  input  logic                                  csr_w_v_i,
  input  logic [4:0]                            csr_data_i,
  output logic [4:0]                            fflags_o,
  output logic                                  busy_o,
  output logic                                  dirty_o,
  input  logic                                  dirty_clr_i,
  input  logic                                  cnt_clr_i,
  output logic [cnt_width_p*num_wb_ports_p-1:0] event_cnt_o
);

  logic [4:0] stage_r, fflags_r, capture, fold_flags, fflags_n;
  logic       stage_v_r, dirty_r, fold, dirty_set;

  always_comb begin
    capture = '0;
    for (int i = 0; i < num_wb_ports_p; i++) begin
      if (wb_fflags_w_v_i[i]) capture = capture | wb_fflags_i[5*i+:5];
    end
  end

  // The staged update is younger than a concurrent CSR write, so it survives it.
  assign fold       = stage_v_r & ~flush_i;
  assign fold_flags = fold ? stage_r : 5'b0;
  assign fflags_n   = csr_w_v_i ? (csr_data_i | fold_flags) : (fflags_r | fold_flags);
  assign dirty_set  = csr_w_v_i | (fold & ((fflags_r | stage_r) != fflags_r));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stage_r   <= '0;
      stage_v_r <= 1'b0;
      fflags_r  <= '0;
      dirty_r   <= 1'b0;
    end else begin
      stage_r   <= capture;
      stage_v_r <= |wb_fflags_w_v_i;
      fflags_r  <= fflags_n;
      if (dirty_set)        dirty_r <= 1'b1;
      else if (dirty_clr_i) dirty_r <= 1'b0;
    end
  end

  assign fflags_o = fflags_r;
  assign busy_o   = stage_v_r;
  assign dirty_o  = dirty_r;

  for (genvar g = 0; g < num_wb_ports_p; g++) begin : g_cnt
    logic [cnt_width_p-1:0] cnt_r;
    logic                   inc;

    assign inc = wb_fflags_w_v_i[g] & (|wb_fflags_i[5*g+:5]) & ~(&cnt_r);

    always_ff @(posedge clk_i) begin
      if (reset_i || cnt_clr_i) cnt_r <= '0;
      else if (inc)             cnt_r <= cnt_r + 1'b1;
    end

    assign event_cnt_o[cnt_width_p*g+:cnt_width_p] = cnt_r;
  end

endmodule

// File: tb/tb_bp_be_fflags_merge.sv
// tb/tb_bp_be_fflags_merge.sv - vector table, corner sequences and random model check for bp_be_fflags_merge
module tb_bp_be_fflags_merge;

  logic        clk = 1'b0;
  logic        rst, flush, cw, dclr, cclr;
  logic [1:0]  v;
  logic [9:0]  fl;
  logic [4:0]  cd;
  logic [4:0]  fflags, s_fflags;
  logic        busy, dirty, s_busy, s_dirty;
  logic [31:0] cnt;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_be_fflags_merge #(.num_wb_ports_p(2), .cnt_width_p(16)) dut (
    .clk_i(clk), .reset_i(rst), .wb_fflags_w_v_i(v), .wb_fflags_i(fl), .flush_i(flush),
    .csr_w_v_i(cw), .csr_data_i(cd), .fflags_o(fflags), .busy_o(busy), .dirty_o(dirty),
    .dirty_clr_i(dclr), .cnt_clr_i(cclr), .event_cnt_o(cnt)
  );

  bp_be_fflags_merge #(.num_wb_ports_p(2), .cnt_width_p(2)) dut_s (
    .clk_i(clk), .reset_i(rst), .wb_fflags_w_v_i(v), .wb_fflags_i(fl), .flush_i(flush),
    .csr_w_v_i(cw), .csr_data_i(cd), .fflags_o(s_fflags), .busy_o(s_busy), .dirty_o(s_dirty),
    .dirty_clr_i(dclr), .cnt_clr_i(cclr), .event_cnt_o(s_cnt)
  );

  typedef struct {
    logic       rst;
    logic [1:0] v;
    logic [4:0] f0, f1;
    logic       flush, cw;
    logic [4:0] cd;
    logic       dclr, cclr;
    logic [4:0] e_ff;
    logic       e_busy, e_dirty;
    int         e_c0, e_c1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [1:0] vv, logic [4:0] f0, logic [4:0] f1,
                              logic fs, logic w, logic [4:0] d, logic dc, logic cc,
                              logic [4:0] eff, logic eb, logic ed, int c0, int c1);
    vec_t t;
    t.rst = r; t.v = vv; t.f0 = f0; t.f1 = f1; t.flush = fs; t.cw = w; t.cd = d;
    t.dclr = dc; t.cclr = cc; t.e_ff = eff; t.e_busy = eb; t.e_dirty = ed;
    t.e_c0 = c0; t.e_c1 = c1;
    return t;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic [1:0] vv, logic [4:0] f0, logic [4:0] f1, logic fs,
                       logic w, logic [4:0] d, logic dc, logic cc);
    rst = r; v = vv; fl = {f1, f0}; flush = fs; cw = w; cd = d; dclr = dc; cclr = cc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference state: architectural view of what has been written back and retired.
  logic [4:0] m_ff, m_pend;
  logic       m_pend_v, m_dirty;
  int         m_cnt[2], m_scnt[2];

  task automatic model_step();
    logic [4:0] add;
    logic       fold, chg;
    if (rst) begin
      m_ff = 0; m_pend = 0; m_pend_v = 0; m_dirty = 0;
      m_cnt = '{0, 0}; m_scnt = '{0, 0};
    end else begin
      fold = m_pend_v && !flush;
      add  = fold ? m_pend : 5'b0;
      chg  = fold && ((m_ff | add) != m_ff);
      m_ff = cw ? (cd | add) : (m_ff | add);
      if (cw || chg) m_dirty = 1;
      else if (dclr) m_dirty = 0;
      m_pend = 0;
      for (int i = 0; i < 2; i++) begin
        if (v[i]) m_pend = m_pend | fl[5*i+:5];
        if (cclr) begin
          m_cnt[i] = 0; m_scnt[i] = 0;
        end else if (v[i] && fl[5*i+:5] != 0) begin
          m_cnt[i]  = (m_cnt[i] + 1 > 65535) ? 65535 : m_cnt[i] + 1;
          m_scnt[i] = (m_scnt[i] + 1 > 3) ? 3 : m_scnt[i] + 1;
        end
      end
      m_pend_v = |v;
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl.push_back(mk(1, 2'b00, 5'h00, 5'h00, 0, 0, 5'h00, 0, 0, 5'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 5'h01, 5'h04, 0, 0, 5'h00, 0, 0, 5'h00, 1, 0, 1, 1));
    tbl.push_back(mk(0, 2'b00, 5'h00, 5'h00, 0, 0, 5'h00, 0, 0, 5'h05, 0, 1, 1, 1));
    tbl.push_back(mk(1, 2'b00, 5'h00, 5'h00, 0, 0, 5'h00, 0, 0, 5'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 5'h08, 5'h00, 0, 0, 5'h00, 0, 0, 5'h00, 1, 0, 1, 0));
    tbl.push_back(mk(0, 2'b00, 5'h00, 5'h00, 1, 0, 5'h00, 0, 0, 5'h00, 0, 0, 1, 0));
    tbl.push_back(mk(0, 2'b00, 5'h00, 5'h00, 0, 0, 5'h00, 0, 0, 5'h00, 0, 0, 1, 0));
    tbl.push_back(mk(0, 2'b01, 5'h01, 5'h00, 0, 0, 5'h00, 0, 0, 5'h00, 1, 0, 2, 0));
    tbl.push_back(mk(0, 2'b10, 5'h00, 5'h08, 0, 0, 5'h00, 0, 0, 5'h01, 1, 1, 2, 1));
    tbl.push_back(mk(0, 2'b00, 5'h00, 5'h00, 0, 1, 5'h10, 0, 0, 5'h18, 0, 1, 2, 1));
    tbl.push_back(mk(0, 2'b00, 5'h00, 5'h00, 0, 1, 5'h01, 0, 0, 5'h01, 0, 1, 2, 1));
    tbl.push_back(mk(0, 2'b01, 5'h01, 5'h00, 0, 0, 5'h00, 1, 0, 5'h01, 1, 0, 3, 1));
    tbl.push_back(mk(0, 2'b00, 5'h00, 5'h00, 0, 0, 5'h00, 0, 0, 5'h01, 0, 0, 3, 1));
    tbl.push_back(mk(0, 2'b00, 5'h00, 5'h00, 0, 1, 5'h00, 1, 0, 5'h00, 0, 1, 3, 1));
    tbl.push_back(mk(0, 2'b11, 5'h00, 5'h04, 0, 0, 5'h00, 0, 1, 5'h00, 1, 1, 0, 0));
    tbl.push_back(mk(0, 2'b01, 5'h00, 5'h00, 0, 0, 5'h00, 0, 0, 5'h04, 1, 1, 0, 0));
    tbl.push_back(mk(0, 2'b00, 5'h00, 5'h00, 0, 0, 5'h00, 0, 0, 5'h04, 0, 1, 0, 0));
    tbl.push_back(mk(0, 2'b11, 5'h10, 5'h02, 0, 0, 5'h00, 0, 0, 5'h04, 1, 1, 1, 1));
    tbl.push_back(mk(1, 2'b00, 5'h00, 5'h00, 0, 0, 5'h00, 0, 0, 5'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 5'h00, 5'h00, 0, 0, 5'h00, 0, 0, 5'h00, 0, 0, 0, 0));

    #2;
    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].v, tbl[k].f0, tbl[k].f1, tbl[k].flush, tbl[k].cw,
            tbl[k].cd, tbl[k].dclr, tbl[k].cclr);
      tick();
      check($sformatf("vec%0d fflags", k), fflags, tbl[k].e_ff);
      check($sformatf("vec%0d busy", k), busy, tbl[k].e_busy);
      check($sformatf("vec%0d dirty", k), dirty, tbl[k].e_dirty);
      check($sformatf("vec%0d cnt0", k), cnt[15:0], tbl[k].e_c0);
      check($sformatf("vec%0d cnt1", k), cnt[31:16], tbl[k].e_c1);
    end

    // Narrow counters saturate at 3, then clear wins over a concurrent increment.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int n = 0; n < 5; n++) begin
      drive(0, 2'b10, 0, 5'h02, 0, 0, 0, 0, 0);
      tick();
      check($sformatf("sat cnt1 step%0d", n), s_cnt[3:2], (n < 3) ? n + 1 : 3);
    end
    drive(0, 2'b10, 0, 5'h02, 0, 0, 0, 0, 1);
    tick();
    check("sat clr cnt1", s_cnt[3:2], 0);
    check("sat clr cnt0", s_cnt[1:0], 0);
    check("wide clr cnt1", cnt[31:16], 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    model_step();
    for (int n = 0; n < 800; n++) begin
      drive(($urandom_range(0, 49) == 0), 2'($urandom), 5'($urandom) & {5{$urandom_range(0, 3) != 0}},
            5'($urandom) & {5{$urandom_range(0, 3) != 0}}, ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0), 5'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 39) == 0));
      tick();
      model_step();
      check("rnd fflags", fflags, m_ff);
      check("rnd busy", busy, m_pend_v);
      check("rnd dirty", dirty, m_dirty);
      check("rnd cnt0", cnt[15:0], m_cnt[0]);
      check("rnd cnt1", cnt[31:16], m_cnt[1]);
      check("rnd s_cnt0", s_cnt[1:0], m_scnt[0]);
      check("rnd s_cnt1", s_cnt[3:2], m_scnt[1]);
      check("rnd s_fflags", s_fflags, m_ff);
      check("rnd s_busy", s_busy, m_pend_v);
      check("rnd s_dirty", s_dirty, m_dirty);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
